// File: rtl/ascon_csr_driver_if.sv
// Job, result and Avalon-MM bus signals between the ASCON CSR driver and its environment.
// The master modport is the driver's view; the slave modport is the sequencer-plus-CSR side.
interface ascon_csr_driver_if;
    logic         job_valid;
    logic         job_ready;
    logic [1:0]   job_mode;
    logic [127:0] job_key;
    logic [127:0] job_nonce;
    logic [127:0] job_ad;
    logic [127:0] job_data;

    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_ct;
    logic [127:0] res_tag;
    logic [127:0] res_pt;
    logic         res_error;
    logic         res_timeout;
    logic         busy;

    logic         chipselect;
    logic         write;
    logic         read;
    logic [4:0]   address;
    logic [31:0]  writedata;
    logic [31:0]  readdata;

    modport master (
        input  job_valid, job_mode, job_key, job_nonce, job_ad, job_data,
        input  res_ready, readdata,
        output job_ready, res_valid, res_ct, res_tag, res_pt, res_error, res_timeout, busy,
        output chipselect, write, read, address, writedata
    );

    modport slave (
        output job_valid, job_mode, job_key, job_nonce, job_ad, job_data,
        output res_ready, readdata,
        input  job_ready, res_valid, res_ct, res_tag, res_pt, res_error, res_timeout, busy,
        input  chipselect, write, read, address, writedata
    );
endinterface

// File: rtl/ascon_csr_driver.sv
// Avalon-MM master that runs one ASCON job through the CSR slave: config writes, start, status
// polling, clear, result readback. Define ASCON_DRV_TIMEOUT_EN to enable the poll timeout.
module ascon_csr_driver #(
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned MAX_POLLS = 1024
) (
    input logic                clk,
    input logic                rst,
    ascon_csr_driver_if.master bus
);

    localparam int unsigned     GapW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GapW-1:0] GapLast    = GapW'(POLL_GAP - 1);
    localparam logic [4:0]      AddrCtrl   = 5'h00;
    localparam logic [4:0]      AddrStatus = 5'h0D;

    // The poll counter is 11 bits wide, so the limit has to fit.
    if (MAX_POLLS == 0 || MAX_POLLS > 2047) begin : g_bad_max_polls
        $error("MAX_POLLS must be in 1..2047");
    end

    typedef enum logic [3:0] {
        StIdle,
        StWrCfg,
        StWrStart,
        StPollRd,
        StPollCap,
        StPollGap,
        StWrClr,
        StRdRes,
        StRdLast,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [511:0]    cfg_q, cfg_d;
    logic [1:0]      mode_q, mode_d;
    logic [383:0]    res_q, res_d;
    logic            err_q, err_d;
`ifdef ASCON_DRV_TIMEOUT_EN
    logic [10:0]     poll_q, poll_d;
    logic            tout_q, tout_d;
`endif

    logic        cs, wr, rd;
    logic [4:0]  addr;
    logic [31:0] wdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        cfg_d   = cfg_q;
        mode_d  = mode_q;
        res_d   = res_q;
        err_d   = err_q;
`ifdef ASCON_DRV_TIMEOUT_EN
        poll_d  = poll_q;
        tout_d  = tout_q;
`endif
        cs      = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        addr    = '0;
        wdata   = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.job_valid) begin
                    cfg_d   = {bus.job_key, bus.job_nonce, bus.job_ad, bus.job_data};
                    mode_d  = bus.job_mode;
                    res_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
`ifdef ASCON_DRV_TIMEOUT_EN
                    poll_d  = '0;
                    tout_d  = 1'b0;
`endif
                    state_d = StWrCfg;
                end
            end

            // Job words leave MSB first; the shifted-out register is not needed afterwards.
            StWrCfg: begin
                cs    = 1'b1;
                wr    = 1'b1;
                addr  = {1'b0, cnt_q} + 5'd1;
                wdata = cfg_q[511 -: 32];
                cfg_d = {cfg_q[479:0], 32'd0};
                if (cnt_q == 4'd15) begin
                    state_d = StWrStart;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            StWrStart: begin
                cs      = 1'b1;
                wr      = 1'b1;
                addr    = AddrCtrl;
                wdata   = {29'd0, mode_q, 1'b1};
                state_d = StPollRd;
            end

            StPollRd: begin
                cs      = 1'b1;
                rd      = 1'b1;
                addr    = AddrStatus;
`ifdef ASCON_DRV_TIMEOUT_EN
                if (poll_q != 11'(MAX_POLLS)) begin
                    poll_d = poll_q + 11'd1;
                end
`endif
                state_d = StPollCap;
            end

            StPollCap: begin
                if (bus.readdata[0]) begin
                    err_d   = bus.readdata[1];
                    state_d = StWrClr;
                end
`ifdef ASCON_DRV_TIMEOUT_EN
                else if (poll_q == 11'(MAX_POLLS)) begin
                    err_d   = 1'b1;
                    tout_d  = 1'b1;
                    state_d = StWrClr;
                end
`endif
                else if (POLL_GAP == 0) begin
                    state_d = StPollRd;
                end else begin
                    gap_d   = '0;
                    state_d = StPollGap;
                end
            end

            StPollGap: begin
                if (gap_q == GapLast) begin
                    state_d = StPollRd;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            StWrClr: begin
                cs    = 1'b1;
                wr    = 1'b1;
                addr  = AddrCtrl;
                wdata = {29'd0, mode_q, 1'b0};
                cnt_d = '0;
`ifdef ASCON_DRV_TIMEOUT_EN
                state_d = tout_q ? StResp : StRdRes;
`else
                state_d = StRdRes;
`endif
            end

            // Pipelined readback: each cycle issues one read and captures the previous one.
            StRdRes: begin
                cs   = 1'b1;
                rd   = 1'b1;
                addr = {1'b0, cnt_q} + 5'd1;
                if (cnt_q != 4'd0) begin
                    res_d = {res_q[351:0], bus.readdata};
                end
                if (cnt_q == 4'd11) begin
                    state_d = StRdLast;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            StRdLast: begin
                res_d   = {res_q[351:0], bus.readdata};
                state_d = StResp;
            end

            StResp: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            gap_q   <= '0;
            cfg_q   <= '0;
            mode_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
`ifdef ASCON_DRV_TIMEOUT_EN
            poll_q  <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            cfg_q   <= cfg_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
            err_q   <= err_d;
`ifdef ASCON_DRV_TIMEOUT_EN
            poll_q  <= poll_d;
            tout_q  <= tout_d;
`endif
        end
    end

    assign bus.job_ready  = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle);
    assign bus.res_valid  = (state_q == StResp);
    assign bus.res_ct     = res_q[383:256];
    assign bus.res_tag    = res_q[255:128];
    assign bus.res_pt     = res_q[127:0];
    assign bus.res_error  = err_q;
`ifdef ASCON_DRV_TIMEOUT_EN
    assign bus.res_timeout = tout_q;
`else
    assign bus.res_timeout = 1'b0;
`endif

    assign bus.chipselect = cs;
    assign bus.write      = wr;
    assign bus.read       = rd;
    assign bus.address    = addr;
    assign bus.writedata  = wdata;

endmodule

// File: tb/tb_ascon_csr_driver.sv
// Bench for ascon_csr_driver: CSR slave model, bus command log and a job-level reference model
// that predicts every bus command, its cycle, and the returned result fields.
module tb_ascon_csr_driver;

    localparam int unsigned PollGap  = 4;
    localparam int unsigned MaxPolls = 8;

    typedef struct packed {
        logic [31:0] cyc;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ascon_csr_driver_if bus ();

    ascon_csr_driver #(
        .POLL_GAP (PollGap),
        .MAX_POLLS(MaxPolls)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    int   cyc        = 0;
    int   proto_errs = 0;
    int   status_cnt = 0;
    int   done_after = 3;
    bit   status_err = 1'b0;
    cmd_t log_q[$];
    logic [31:0] rd_words [1:12];

    // Command log, protocol monitor and CSR slave model.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.chipselect || bus.read || bus.write) begin
            log_q.push_back('{32'(cyc), bus.write, bus.address,
                              bus.write ? bus.writedata : 32'd0});
        end
        if ((bus.read && bus.write) || (bus.chipselect != (bus.read || bus.write)) ||
            (bus.job_ready && (bus.address != 5'd0 || bus.writedata != 32'd0))) begin
            proto_errs <= proto_errs + 1;
        end
        if (bus.chipselect && bus.write && bus.address == 5'd0 && bus.writedata[0]) begin
            status_cnt <= 0;
        end
        if (bus.chipselect && bus.read) begin
            if (bus.address == 5'h0D) begin
                status_cnt <= status_cnt + 1;
                if (done_after != 0 && status_cnt + 1 >= done_after) begin
                    bus.readdata <= ($urandom() & 32'hFFFF_FFFC) | {30'd0, status_err, 1'b1};
                end else begin
                    bus.readdata <= $urandom() & 32'hFFFF_FFFE;
                end
            end else if (bus.address >= 5'd1 && bus.address <= 5'd12) begin
                bus.readdata <= rd_words[bus.address];
            end else begin
                bus.readdata <= $urandom();
            end
        end else begin
            bus.readdata <= $urandom();
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic randomize_words();
        for (int j = 1; j <= 12; j++) rd_words[j] = $urandom();
    endtask

    // Offers one job, waits for its result and checks bus trace, timing and result fields.
    // n_done = status read that reports done (0 = never); hold = cycles res_ready stays low.
    task automatic run_job(input logic [127:0] key, input logic [127:0] nonce,
                           input logic [127:0] ad, input logic [127:0] data,
                           input logic [1:0] mode, input int n_done, input bit err,
                           input int hold, input string name);
        int           base, t_acc, t_resp, exp_resp, n_reads, r, waited, n_act;
        bit           exp_to, exp_err, ok;
        cmd_t         exp_q[$];
        logic [511:0] cfg;
        logic [383:0] exp_res;

        done_after = n_done;
        status_err = err;
        bus.res_ready = (hold == 0);

        waited = 0;
        while (!bus.job_ready && waited < 200) begin
            @(posedge clk); #1; waited++;
        end
        base          = log_q.size();
        bus.job_key   = key;
        bus.job_nonce = nonce;
        bus.job_ad    = ad;
        bus.job_data  = data;
        bus.job_mode  = mode;
        bus.job_valid = 1'b1;
        @(posedge clk);
        t_acc = cyc;
        #1;
        bus.job_valid = 1'b0;
        bus.job_key   = rand128();
        bus.job_nonce = rand128();
        bus.job_ad    = rand128();
        bus.job_data  = rand128();
        bus.job_mode  = 2'($urandom());

        t_resp = -1;
        waited = 0;
        while (!bus.res_valid && waited < 3000) begin
            @(posedge clk); t_resp = cyc; #1; waited++;
        end
        tests_run++;
        if (!bus.res_valid) begin
            tests_failed++;
            $display("FAIL %s res_valid_wait: res_valid=%0b after %0d cycles, required 1",
                     name, bus.res_valid, waited);
            return;
        end

`ifdef ASCON_DRV_TIMEOUT_EN
        exp_to = (n_done == 0) || (n_done > int'(MaxPolls));
`else
        exp_to = 1'b0;
`endif
        n_reads = exp_to ? int'(MaxPolls) : n_done;
        cfg = {key, nonce, ad, data};
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back('{32'(t_acc + 1 + i), 1'b1, 5'(i + 1), cfg[511 - 32 * i -: 32]});
        end
        exp_q.push_back('{32'(t_acc + 17), 1'b1, 5'd0, {29'd0, mode, 1'b1}});
        r = t_acc + 18;
        for (int k = 0; k < n_reads; k++) begin
            exp_q.push_back('{32'(r), 1'b0, 5'h0D, 32'd0});
            if (k < n_reads - 1) r += int'(PollGap) + 2;
        end
        exp_q.push_back('{32'(r + 2), 1'b1, 5'd0, {29'd0, mode, 1'b0}});
        exp_res = '0;
        if (exp_to) begin
            exp_resp = r + 2;
        end else begin
            for (int j = 0; j < 12; j++) begin
                exp_q.push_back('{32'(r + 3 + j), 1'b0, 5'(j + 1), 32'd0});
                exp_res = {exp_res[351:0], rd_words[j + 1]};
            end
            exp_resp = r + 15;
        end
        exp_err = exp_to ? 1'b1 : err;

        tests_run++;
        if (t_resp !== exp_resp) begin
            tests_failed++;
            $display("FAIL %s resp_cycle: got %0d, required %0d", name, t_resp, exp_resp);
        end
        n_act = log_q.size() - base;
        tests_run++;
        if (n_act !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s cmd_count: got %0d, required %0d", name, n_act, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < n_act; i++) begin
            tests_run++;
            if (log_q[base + i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL %s cmd[%0d] {cyc,wr,addr,data}: got %h, required %h",
                         name, i, log_q[base + i], exp_q[i]);
            end
        end
        tests_run++;
        if ({bus.res_ct, bus.res_tag, bus.res_pt} !== exp_res) begin
            tests_failed++;
            $display("FAIL %s res_data: got %h, required %h", name,
                     {bus.res_ct, bus.res_tag, bus.res_pt}, exp_res);
        end
        tests_run++;
        if ({bus.res_error, bus.res_timeout, bus.busy, bus.job_ready} !==
            {exp_err, exp_to, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL %s res_flags {err,tout,busy,job_ready}: got %b, required %b", name,
                     {bus.res_error, bus.res_timeout, bus.busy, bus.job_ready},
                     {exp_err, exp_to, 1'b1, 1'b0});
        end

        if (hold > 0) begin
            ok = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!bus.res_valid || {bus.res_ct, bus.res_tag, bus.res_pt} !== exp_res ||
                    bus.res_error !== exp_err) ok = 1'b0;
            end
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL %s res_hold: got unstable result, required stable for %0d cycles",
                         name, hold);
            end
            bus.res_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        tests_run++;
        if ({bus.res_valid, bus.job_ready, bus.busy} !== 3'b010) begin
            tests_failed++;
            $display("FAIL %s consume {res_valid,job_ready,busy}: got %b, required 010", name,
                     {bus.res_valid, bus.job_ready, bus.busy});
        end
        tests_run++;
        if ({bus.res_ct, bus.res_tag, bus.res_pt, bus.res_error} !== {exp_res, exp_err}) begin
            tests_failed++;
            $display("FAIL %s res_after_consume: got %h, required %h", name,
                     {bus.res_ct, bus.res_tag, bus.res_pt, bus.res_error}, {exp_res, exp_err});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        tests_run++;
        if (bus.job_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset job_ready: got %b, required 1", bus.job_ready);
        end
        tests_run++;
        if ({bus.chipselect, bus.read, bus.write} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset strobes: got %b, required 000",
                     {bus.chipselect, bus.read, bus.write});
        end
        tests_run++;
        if ({bus.res_valid, bus.busy, bus.res_error, bus.res_timeout} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset flags: got %b, required 0000",
                     {bus.res_valid, bus.busy, bus.res_error, bus.res_timeout});
        end
        tests_run++;
        if ({bus.address, bus.writedata, bus.res_ct, bus.res_tag, bus.res_pt} !== '0) begin
            tests_failed++;
            $display("FAIL reset data: got nonzero address/writedata/result, required 0");
        end
    endtask

    task automatic test_known_job();
        for (int j = 1; j <= 4; j++) rd_words[j] = 32'hA5A5A5A5 + 32'(j);
        for (int j = 5; j <= 8; j++) rd_words[j] = 32'h5A5A5A5A + 32'(j);
        for (int j = 9; j <= 12; j++) rd_words[j] = 32'h11111111 * 32'(j - 8);
        run_job(128'h000102030405060708090A0B0C0D0E0F, rand128(), rand128(), rand128(),
                2'd1, 3, 1'b1, 5, "known_job");
    endtask

    task automatic test_random_jobs();
        for (int n = 0; n < 6; n++) begin
            randomize_words();
            run_job(rand128(), rand128(), rand128(), rand128(), 2'($urandom()),
                    int'($urandom_range(1, 5)), 1'($urandom()), int'($urandom_range(0, 3)),
                    "random_job");
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            randomize_words();
            run_job(rand128(), rand128(), rand128(), rand128(), 2'($urandom()),
                    1, 1'b0, 0, "back_to_back");
        end
    endtask

    task automatic test_reset_mid_job();
        int waited;
        bus.job_key   = rand128();
        bus.job_nonce = rand128();
        bus.job_ad    = rand128();
        bus.job_data  = rand128();
        bus.job_mode  = 2'd2;
        bus.job_valid = 1'b1;
        @(posedge clk); #1;
        bus.job_valid = 1'b0;
        waited = 0;
        while (!(bus.write && bus.address == 5'd7) && waited < 50) begin
            @(posedge clk); #1; waited++;
        end
        tests_run++;
        if (!(bus.write && bus.address == 5'd7)) begin
            tests_failed++;
            $display("FAIL mid_reset reach_word7: address=%0d write=%b, required 7/1",
                     bus.address, bus.write);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({bus.chipselect, bus.read, bus.write, bus.job_ready, bus.busy} !== 5'b00010) begin
            tests_failed++;
            $display("FAIL mid_reset {cs,rd,wr,job_ready,busy}: got %b, required 00010",
                     {bus.chipselect, bus.read, bus.write, bus.job_ready, bus.busy});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        randomize_words();
        run_job(rand128(), rand128(), rand128(), rand128(), 2'd3, 2, 1'b0, 1, "after_reset");
    endtask

`ifdef ASCON_DRV_TIMEOUT_EN
    task automatic test_timeout();
        randomize_words();
        run_job(rand128(), rand128(), rand128(), rand128(), 2'd1, 0, 1'b0, 2, "timeout");
    endtask
`endif

    initial begin
        bus.job_valid = 1'b0;
        bus.job_mode  = '0;
        bus.job_key   = '0;
        bus.job_nonce = '0;
        bus.job_ad    = '0;
        bus.job_data  = '0;
        bus.res_ready = 1'b0;
        randomize_words();

        test_reset();
        test_known_job();
        test_random_jobs();
        test_back_to_back();
        test_reset_mid_job();
`ifdef ASCON_DRV_TIMEOUT_EN
        test_timeout();
`endif
        tests_run++;
        if (proto_errs !== 0) begin
            tests_failed++;
            $display("FAIL bus_protocol: got %0d violations, required 0", proto_errs);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
